// File: rtl/bus_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_monitor_pkg
//  Description : Shared types, constants and the rdata reference function
//                used by the bus monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_monitor_pkg;

    localparam logic [7:0] MODE_ADDR  = 8'h00;
    localparam logic [7:0] DONE_VALUE = 8'd1;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] data;
    } xfer_t;

    // Writes echo their data; reads return addr/2 (even mode) or 3*addr+1 (odd mode).
    function automatic logic [7:0] expected_rdata(input xfer_t rec, input logic mode);
        logic [7:0] result;
        if (rec.write) begin
            result = rec.data;
        end else if (!mode) begin
            result = {1'b0, rec.addr[7:1]};
        end else begin
            result = {rec.addr[6:0], 1'b0} + rec.addr + 8'd1;
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_monitor_if
//  Description : Controller/Peripheral bus bundle with master, slave and
//                passive monitor views.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_monitor_if;

    logic       trans;
    logic       write;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       readyout;
    logic [7:0] rdata;

    modport master  (output trans, write, waddr, wdata, input  readyout, rdata);
    modport slave   (input  trans, write, waddr, wdata, output readyout, rdata);
    modport monitor (input  trans, write, waddr, wdata, readyout, rdata);

endinterface
`default_nettype wire

// File: rtl/bus_monitor_queue.sv
`default_nettype none
// ============================================================================
//  Module      : monitor_queue
//  Description : DEPTH-entry FIFO of outstanding transfer records with
//                simultaneous push/pop.
//  Revision    : 1.0 - initial release
// ============================================================================
module monitor_queue
    import bus_monitor_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  wire logic  clock,
    input  wire logic  reset,
    input  wire logic  i_push,
    input  wire logic  i_pop,
    input  wire xfer_t i_rec,
    output xfer_t      o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    xfer_t            mem_q [DEPTH];
    xfer_t            mem_d [DEPTH];
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_head  = mem_q[rd_ptr_q];

    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = i_rec;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (w_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : bus_monitor
//  Description : Passive in-order scoreboard for the 8-bit Controller/
//                Peripheral bus with rdata checking and Collatz statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_monitor
    import bus_monitor_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 4,
    parameter int CNT_W   = 16
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    bus_monitor_if.monitor        bus,
    output logic [CNT_W-1:0]      step_count,
    output logic [7:0]            last_value,
    output logic [7:0]            peak,
    output logic                  done,
    output logic [CNT_W-1:0]      mismatch_count,
    output logic                  proto_err,
    output logic                  overflow_err,
    output logic                  timeout_err
);

    localparam int AGE_W = $clog2(TIMEOUT + 1);

    xfer_t            w_head;
    xfer_t            w_rec;
    logic             w_full;
    logic             w_empty;
    logic             w_retire;
    logic             w_timeout;
    logic             w_pop;
    logic             w_commit;
    logic             w_mismatch;

    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic [7:0]       last_value_q, last_value_d;
    logic [7:0]       peak_q, peak_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] mismatch_count_q, mismatch_count_d;
    logic             proto_err_q, proto_err_d;
    logic             overflow_err_q, overflow_err_d;
    logic             timeout_err_q, timeout_err_d;
    logic             mode_q, mode_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             armed_q, armed_d;

    assign w_rec      = '{write: bus.write, addr: bus.waddr, data: bus.wdata};
    assign w_retire   = bus.readyout && !w_empty;
    assign w_timeout  = !bus.readyout && !w_empty && (age_q == AGE_W'(TIMEOUT - 1));
    assign w_pop      = w_retire || w_timeout;
    assign w_commit   = w_retire && w_head.write && (w_head.addr == MODE_ADDR);
    assign w_mismatch = w_retire && (bus.rdata != expected_rdata(w_head, mode_q));

    monitor_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clock   (clock),
        .reset   (reset),
        .i_push  (bus.trans),
        .i_pop   (w_pop),
        .i_rec   (w_rec),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        step_count_d     = step_count_q;
        last_value_d     = last_value_q;
        peak_d           = peak_q;
        done_d           = done_q;
        mismatch_count_d = mismatch_count_q;
        proto_err_d      = proto_err_q;
        overflow_err_d   = overflow_err_q;
        timeout_err_d    = timeout_err_q;
        mode_d           = mode_q;
        armed_d          = armed_q || bus.trans;
        age_d            = (w_pop || w_empty) ? '0 : age_q + AGE_W'(1);

        // Mode follows committed writes even when clear wipes the statistics.
        if (w_commit) begin
            mode_d = w_head.data[0];
        end

        if (clear) begin
            step_count_d     = '0;
            last_value_d     = '0;
            peak_d           = '0;
            done_d           = 1'b0;
            mismatch_count_d = '0;
            proto_err_d      = 1'b0;
            overflow_err_d   = 1'b0;
            timeout_err_d    = 1'b0;
        end else begin
            if (w_commit) begin
                if (step_count_q != '1) begin
                    step_count_d = step_count_q + CNT_W'(1);
                end
                last_value_d = w_head.data;
                if (w_head.data > peak_q) begin
                    peak_d = w_head.data;
                end
                if (w_head.data == DONE_VALUE) begin
                    done_d = 1'b1;
                end
            end
            if (w_mismatch && (mismatch_count_q != '1)) begin
                mismatch_count_d = mismatch_count_q + CNT_W'(1);
            end
            // Orphan responses only count once something has been issued since reset.
            if (bus.readyout && w_empty && armed_q) begin
                proto_err_d = 1'b1;
            end
            if (bus.trans && w_full && !w_pop) begin
                overflow_err_d = 1'b1;
            end
            if (w_timeout) begin
                timeout_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step_count_q     <= '0;
            last_value_q     <= '0;
            peak_q           <= '0;
            done_q           <= 1'b0;
            mismatch_count_q <= '0;
            proto_err_q      <= 1'b0;
            overflow_err_q   <= 1'b0;
            timeout_err_q    <= 1'b0;
            mode_q           <= 1'b0;
            age_q            <= '0;
            armed_q          <= 1'b0;
        end else begin
            step_count_q     <= step_count_d;
            last_value_q     <= last_value_d;
            peak_q           <= peak_d;
            done_q           <= done_d;
            mismatch_count_q <= mismatch_count_d;
            proto_err_q      <= proto_err_d;
            overflow_err_q   <= overflow_err_d;
            timeout_err_q    <= timeout_err_d;
            mode_q           <= mode_d;
            age_q            <= age_d;
            armed_q          <= armed_d;
        end
    end

    assign step_count     = step_count_q;
    assign last_value     = last_value_q;
    assign peak           = peak_q;
    assign done           = done_q;
    assign mismatch_count = mismatch_count_q;
    assign proto_err      = proto_err_q;
    assign overflow_err   = overflow_err_q;
    assign timeout_err    = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_monitor
//  Description : Self-checking bench for bus_monitor against a queue-based
//                reference model of the bus rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_monitor;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic [CNT_W-1:0] step_count;
    logic [7:0]       last_value;
    logic [7:0]       peak;
    logic             done;
    logic [CNT_W-1:0] mismatch_count;
    logic             proto_err;
    logic             overflow_err;
    logic             timeout_err;
    logic [51:0]      dut_vec;

    bus_monitor_if bus ();

    bus_monitor #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .bus            (bus),
        .step_count     (step_count),
        .last_value     (last_value),
        .peak           (peak),
        .done           (done),
        .mismatch_count (mismatch_count),
        .proto_err      (proto_err),
        .overflow_err   (overflow_err),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    assign dut_vec = {step_count, last_value, peak, done, mismatch_count,
                      proto_err, overflow_err, timeout_err};

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: an in-order list of outstanding transfers plus plain counters.
    typedef struct {
        bit w;
        int a;
        int d;
    } mrec_t;

    mrec_t mq[$];
    int    m_age, m_step, m_last, m_peak, m_mism;
    bit    m_mode, m_armed, m_done, m_proto, m_ovf, m_to;

    function automatic int tb_exp(mrec_t r, bit mode);
        if (r.w)   return r.d;
        if (!mode) return r.a / 2;
        return (3 * r.a + 1) % 256;
    endfunction

    function automatic logic [51:0] model_vec();
        logic [15:0] s, mm;
        logic [7:0]  l, p;
        s  = m_step[15:0];
        mm = m_mism[15:0];
        l  = m_last[7:0];
        p  = m_peak[7:0];
        return {s, l, p, m_done, mm, m_proto, m_ovf, m_to};
    endfunction

    task automatic model_reset();
        mq.delete();
        m_age = 0; m_step = 0; m_last = 0; m_peak = 0; m_mism = 0;
        m_mode = 0; m_armed = 0; m_done = 0; m_proto = 0; m_ovf = 0; m_to = 0;
    endtask

    // One clock: drive inputs, advance the model by one edge, settle past the edge.
    // rd < 0 means "respond as a correct peripheral would".
    task automatic cyc(input bit tr, input bit wr, input int a, input int d,
                       input bit ro, input int rd, input bit clr);
        int    rdv, sz0;
        bit    popped;
        mrec_t h, nr;
        if (rd >= 0)            rdv = rd;
        else if (mq.size() > 0) rdv = tb_exp(mq[0], m_mode);
        else                    rdv = int'($urandom_range(0, 255));
        bus.trans    = tr;
        bus.write    = wr;
        bus.waddr    = a[7:0];
        bus.wdata    = d[7:0];
        bus.readyout = ro;
        bus.rdata    = rdv[7:0];
        clear        = clr;
        @(posedge clock);
        sz0    = mq.size();
        popped = 0;
        if (ro && sz0 == 0 && m_armed) m_proto = 1;
        if (ro && sz0 > 0) begin
            h = mq.pop_front();
            popped = 1;
            if (rdv != tb_exp(h, m_mode) && m_mism < CNT_MAX) m_mism++;
            if (h.w && h.a == 0) begin
                m_mode = (h.d % 2 == 1);
                if (m_step < CNT_MAX) m_step++;
                m_last = h.d;
                if (h.d > m_peak) m_peak = h.d;
                if (h.d == 1) m_done = 1;
            end
        end else if (sz0 > 0 && m_age + 1 >= TIMEOUT) begin
            void'(mq.pop_front());
            popped = 1;
            m_to   = 1;
        end
        if (tr) begin
            m_armed = 1;
            if (mq.size() < DEPTH) begin
                nr.w = wr; nr.a = a % 256; nr.d = d % 256;
                mq.push_back(nr);
            end else begin
                m_ovf = 1;
            end
        end
        if (popped || sz0 == 0) m_age = 0;
        else                    m_age++;
        if (clr) begin
            m_step = 0; m_last = 0; m_peak = 0; m_done = 0; m_mism = 0;
            m_proto = 0; m_ovf = 0; m_to = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        bus.trans = 0; bus.write = 0; bus.waddr = 0; bus.wdata = 0;
        bus.readyout = 0; bus.rdata = 0; clear = 0;
        reset = 1;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (dut_vec !== 52'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", dut_vec);
        end
        // Orphan readyout right after reset must not flag a protocol error.
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_orphan_proto: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_collatz();
        int vals[8] = '{3, 10, 5, 16, 8, 4, 2, 1};
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) cyc(1, 1, 0, vals[i / 2], i > 0, -1, 0);
            else            cyc(1, 0, int'($urandom_range(1, 255)), 0, 1, -1, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL collatz_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if ({step_count, peak, last_value, done, mismatch_count} !== {16'd8, 8'd16, 8'd1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL collatz_final: got step=%0d peak=%0d last=%0d done=%b mism=%0d expected 8 16 1 1 0",
                     step_count, peak, last_value, done, mismatch_count);
        end
        n_checks++;
        if ({proto_err, overflow_err, timeout_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL collatz_errors: got %b expected 000", {proto_err, overflow_err, timeout_err});
        end
    endtask

    task automatic test_mode_wrap();
        cyc(0, 0, 0, 0, 0, -1, 1);
        cyc(1, 1, 0, 1, 0, -1, 0);
        cyc(1, 0, 100, 0, 1, -1, 0);
        cyc(1, 0, 100, 0, 1, 45, 0);
        n_checks++;
        if (mismatch_count !== 16'd0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL mode_wrap_45: got mism=%0d vec=%h expected 0 vec=%h", mismatch_count, dut_vec, model_vec());
        end
        cyc(0, 0, 0, 0, 1, 46, 0);
        n_checks++;
        if (mismatch_count !== 16'd1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL mode_wrap_46: got mism=%0d vec=%h expected 1 vec=%h", mismatch_count, dut_vec, model_vec());
        end
    endtask

    task automatic test_proto();
        cyc(0, 0, 0, 0, 0, -1, 1);
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_before: got %b expected 0", proto_err);
        end
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if (proto_err !== 1'b1 || step_count !== 16'd0 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL proto_orphan: got proto=%b step=%0d expected 1 0", proto_err, step_count);
        end
    endtask

    task automatic test_overflow_timeout();
        cyc(0, 0, 0, 0, 0, -1, 1);
        cyc(1, 0, 10, 0, 0, -1, 0);
        cyc(1, 0, 20, 0, 0, -1, 0);
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_early: got %b expected 0", overflow_err);
        end
        cyc(1, 0, 30, 0, 0, -1, 0);
        n_checks++;
        if (overflow_err !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL overflow_third: got %b expected 1", overflow_err);
        end
        for (int i = 0; i < TIMEOUT; i++) begin
            cyc(0, 0, 0, 0, 0, -1, 0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL timeout_wait%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_flag: got %b expected 1", timeout_err);
        end
        // Surviving head is the second read; a correct reply for it must not mismatch.
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if (mismatch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL timeout_discard: got mism=%0d expected 0", mismatch_count);
        end
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if (proto_err !== 1'b1 || dut_vec !== model_vec()) begin
            n_fail++;
            $display("FAIL timeout_drained: got proto=%b expected 1", proto_err);
        end
    endtask

    task automatic test_clear_reset();
        int vals[8] = '{3, 10, 5, 16, 8, 4, 2, 1};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) cyc(1, 1, 0, vals[i / 2], i > 0, -1, i == 10);
            else            cyc(1, 0, int'($urandom_range(1, 255)), 0, 1, -1, i == 10);
            if (i == 10) begin
                n_checks++;
                if (dut_vec !== 52'd0) begin
                    n_fail++;
                    $display("FAIL clear_zero: got %h expected 0", dut_vec);
                end
            end
            if (i == 11) begin
                n_checks++;
                if (step_count !== 16'd1) begin
                    n_fail++;
                    $display("FAIL clear_restart: got step=%0d expected 1", step_count);
                end
            end
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL clear_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if ({step_count, peak, last_value, done, mismatch_count} !== {16'd3, 8'd4, 8'd1, 1'b1, 16'd0}) begin
            n_fail++;
            $display("FAIL clear_final: got step=%0d peak=%0d last=%0d done=%b mism=%0d expected 3 4 1 1 0",
                     step_count, peak, last_value, done, mismatch_count);
        end
        cyc(1, 0, 5, 0, 0, -1, 0);
        cyc(1, 1, 0, 7, 0, -1, 0);
        do_reset();
        n_checks++;
        if (dut_vec !== 52'd0) begin
            n_fail++;
            $display("FAIL midreset_zero: got %h expected 0", dut_vec);
        end
        cyc(0, 0, 0, 0, 1, -1, 0);
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_orphan: got %b expected 0", proto_err);
        end
        cyc(1, 1, 0, 9, 0, -1, 0);
        cyc(0, 0, 0, 0, 1, 9, 0);
        n_checks++;
        if ({step_count, last_value, mismatch_count} !== {16'd1, 8'd9, 16'd0}) begin
            n_fail++;
            $display("FAIL midreset_fresh: got step=%0d last=%0d mism=%0d expected 1 9 0",
                     step_count, last_value, mismatch_count);
        end
    endtask

    task automatic test_random();
        bit tr, wr, ro, clr;
        int a, rd;
        cyc(0, 0, 0, 0, 0, -1, 1);
        for (int i = 0; i < 400; i++) begin
            tr  = ($urandom_range(0, 3) != 0);
            wr  = $urandom_range(0, 1) == 1;
            a   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
            ro  = ($urandom_range(0, 4) != 0);
            rd  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : -1;
            clr = ($urandom_range(0, 49) == 0);
            cyc(tr, wr, a, int'($urandom_range(0, 255)), ro, rd, clr);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, model_vec());
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        void'($urandom(3));
        test_reset();
        test_collatz();
        test_mode_wrap();
        test_proto();
        test_overflow_timeout();
        test_clear_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_monitor.md
Name: bus_monitor

Overview:
- Passive in-line checker/scoreboard on the 8-bit Controller↔Peripheral bus; drives no bus signal.
- Tracks every transfer from issue (trans) to response (readyout) in order.
- Models the Peripheral's even/odd mode to check rdata, and gathers Collatz statistics (step count, peak, done) from committed writes to address 0.
- Used in simulation and optionally as on-chip debug.

Parameters:
- DEPTH, 2, max outstanding transfers (≥2; bus issues back-to-back transfers)
- TIMEOUT, 4, max cycles a transfer may wait for readyout before being flagged and discarded
- CNT_W, 16, width of step_count and mismatch_count

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- clear  input  1  synchronous; zeroes statistics and sticky flags only
- trans  input  1  bus transfer valid (Controller)
- write  input  1  1=write, 0=read
- waddr  input  8  transfer address
- wdata  input  8  write data
- readyout  input  1  response valid (Peripheral)
- rdata  input  8  response data
- step_count  output  CNT_W  committed addr-0 writes, saturating
- last_value  output  8  wdata of latest committed addr-0 write
- peak  output  8  max committed addr-0 value since reset/clear
- done  output  1  sticky; set when an addr-0 commit has wdata==1
- mismatch_count  output  CNT_W  rdata check failures, saturating
- proto_err  output  1  sticky; readyout with empty queue
- overflow_err  output  1  sticky; issue dropped because queue full
- timeout_err  output  1  sticky; head exceeded TIMEOUT

Behaviour:
- Reset: all outputs 0, queue empty, model mode=0 (even), age counter 0.
- Issue: each rising edge with trans=1 pushes {write,waddr,wdata} to the tail.
- Retire: each edge with readyout=1 pops the head and checks it.
- Expected bus timing: readyout one cycle after trans. Back-to-back trans gives push and pop on the same edge; this is legal and the queue count is unchanged.
- Full queue with trans=1 and no same-edge pop: the transfer is dropped and overflow_err is set.
- readyout=1 with empty queue and no valid head: proto_err is set and nothing else changes. A push on the same edge does not satisfy that readyout.
- Check on retire of a write:
  - Expected rdata = head wdata.
  - If head waddr==0: model mode<=wdata[0], step_count+1 (saturating), last_value<=wdata, peak<=max(peak,wdata), done<=1 if wdata==8'd1.
- Check on retire of a read:
  - Expected rdata = waddr>>1 if mode=0.
  - Expected rdata = (3*waddr+1) mod 256 if mode=1 (8-bit truncation).
  - Mode is the value in effect at retire, after any earlier writes retired.
- Mismatch: rdata≠expected increments mismatch_count (saturating). Statistics still update from wdata.
- Age: counts cycles the current head has waited, resetting to 0 whenever the head changes. When age reaches TIMEOUT without readyout: timeout_err is set, the head is popped without a check, and age returns to 0.
- clear:
  - Zeroes step_count, last_value, peak, done, mismatch_count and all three error flags.
  - Does not touch the queue, model mode or age.
  - If clear and a retire coincide, clear wins for statistics, but the mode update still occurs.
- Reset mid-transfer discards all outstanding entries; no error is raised on later orphan readyout until a new issue.
- All outputs are registered; a statistic is visible the cycle after its retire edge.

Decomposition:
- Shared package:
  - MODE_ADDR=8'h00 and DONE_VALUE=8'd1.
  - Transfer record type {write, addr[7:0], data[7:0]}.
  - Pure function expected_rdata(rec, mode).
- Sub-module monitor_queue:
  - Parameterised DEPTH FIFO of transfer records.
  - Simultaneous push/pop, full/empty flags, asynchronous active-high reset.
- Top level holds the mode model, age counter, checks and statistics.

Test Plan:
- Bus driven as Controller seeded 3 with a correct Peripheral model:
  - Required commits 3,10,5,16,8,4,2,1 → step_count=8, peak=16, last_value=1, done=1, mismatch_count=0, all error flags 0.
- Mode check and wrap:
  - Write 8'd1 to addr 0, then read addr 8'd100 with response 8'd45 → mismatch_count=0 (301 mod 256=45).
  - Same read with response 8'd46 → mismatch_count=1.
- readyout=1 for one cycle with no prior trans → proto_err=1, step_count unchanged.
- Three trans cycles with readyout held 0 (DEPTH=2) → overflow_err=1 on the third issue.
- Then readyout held 0 for TIMEOUT=4 more cycles → timeout_err=1 and the head is discarded.
- Mid-sequence, at step_count=5:
  - Assert clear for one cycle → all statistics 0 next cycle.
  - Continuing the sequence → step_count counts from 1 and mode checking remains correct.
  - Then assert reset with 2 entries queued → all outputs 0 and the queue empty.
